// File: rtl/sram_backup.sv
// Save-RAM backup engine: loads an SD image into the 1 MB save-RAM window on mount and writes it back on request.
// Optional build macro SRAM_BACKUP_DIRTY_EN: saves run only after a CPU write since the last mount or save.
module sram_backup (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        img_mounted,
  input  logic [31:0] img_size,
  input  logic [23:0] ram_mask,
  input  logic        save_req,
  input  logic        cpu_wr,
  output logic [31:0] sd_lba,
  output logic        sd_rd,
  output logic        sd_wr,
  input  logic        sd_ack,
  input  logic [8:0]  sd_buff_addr,
  input  logic [7:0]  sd_buff_dout,
  output logic [7:0]  sd_buff_din,
  input  logic        sd_buff_wr,
  output logic [19:0] mem_addr,
  output logic [7:0]  mem_din,
  input  logic [7:0]  mem_dout,
  output logic        mem_we,
  output logic        mem_req,
  input  logic        mem_ack,
  output logic        busy,
  output logic        mounted,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_XFER = 3'd2,
    RD_COPY = 3'd3,
    WR_FILL = 3'd4,
    WR_REQ  = 3'd5,
    WR_XFER = 3'd6
  } state_t;

  localparam logic [1:0] PH_ADDR = 2'd0;
  localparam logic [1:0] PH_REQ  = 2'd1;
  localparam logic [1:0] PH_WAIT = 2'd2;

  state_t      state_q;
  logic [15:0] sector_q;
  logic [22:0] tgt_q;
  logic [8:0]  idx_q;
  logic [1:0]  phase_q;
  logic [31:0] sd_lba_q;
  logic        sd_rd_q;
  logic        sd_wr_q;
  logic [19:0] mem_addr_q;
  logic [7:0]  mem_din_q;
  logic        mem_we_q;
  logic        mem_req_q;
  logic        mounted_q;
  logic [7:0]  sd_buff_din_q;
  logic [7:0]  buf_q [0:511];

  logic [15:0] nsec;
  logic [22:0] load_cnt;
  logic [15:0] sector_inc;
  logic        last_sector;
  logic        mem_done;
  logic        fill_wr;
  logic        start_save;
  logic        save_ok;

  assign nsec        = (ram_mask != 24'd0) ? ({1'b0, ram_mask[23:9]} + 16'd1) : 16'd0;
  assign load_cnt    = ({7'd0, nsec} < img_size[31:9]) ? {7'd0, nsec} : img_size[31:9];
  assign sector_inc  = sector_q + 16'd1;
  assign last_sector = ({7'd0, sector_inc} == tgt_q);
  assign mem_done    = (mem_ack == mem_req_q);
  assign fill_wr     = (state_q == WR_FILL) && (phase_q == PH_WAIT) && mem_done;
  assign start_save  = (state_q == IDLE) && !img_mounted && save_req && mounted_q &&
                       (nsec != 16'd0) && save_ok;

`ifdef SRAM_BACKUP_DIRTY_EN
  logic dirty_q;
  logic fill_entry;
  logic in_read;

  assign fill_entry = start_save || ((state_q == WR_XFER) && !sd_ack && !last_sector);
  assign in_read    = (state_q == RD_REQ) || (state_q == RD_XFER) || (state_q == RD_COPY);
  assign save_ok    = dirty_q;

  // A CPU write wins over a same-cycle clear so no write is ever forgotten.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      dirty_q <= 1'b0;
    end else if (cpu_wr && !in_read) begin
      dirty_q <= 1'b1;
    end else if (img_mounted || fill_entry) begin
      dirty_q <= 1'b0;
    end
  end
`else
  logic unused_cpu_wr;
  assign unused_cpu_wr = cpu_wr;
  assign save_ok       = 1'b1;
`endif

  // Sector buffer: no reset; the engine fills it during a save, the SD side otherwise.
  always_ff @(posedge clk_sys) begin
    if (fill_wr) begin
      buf_q[idx_q] <= mem_dout;
    end else if (sd_buff_wr) begin
      buf_q[sd_buff_addr] <= sd_buff_dout;
    end
    sd_buff_din_q <= buf_q[sd_buff_addr];
  end

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      sector_q   <= 16'd0;
      tgt_q      <= 23'd0;
      idx_q      <= 9'd0;
      phase_q    <= PH_ADDR;
      sd_lba_q   <= 32'd0;
      sd_rd_q    <= 1'b0;
      sd_wr_q    <= 1'b0;
      mem_addr_q <= 20'd0;
      mem_din_q  <= 8'd0;
      mem_we_q   <= 1'b0;
      mem_req_q  <= mem_ack;
      mounted_q  <= 1'b0;
    end else begin
      if (img_mounted) begin
        mounted_q <= (img_size != 32'd0);
      end
      case (state_q)
        IDLE: begin
          if (img_mounted) begin
            if (load_cnt != 23'd0) begin
              state_q  <= RD_REQ;
              sector_q <= 16'd0;
              tgt_q    <= load_cnt;
              sd_lba_q <= 32'd0;
              sd_rd_q  <= 1'b1;
            end
          end else if (start_save) begin
            state_q  <= WR_FILL;
            sector_q <= 16'd0;
            tgt_q    <= {7'd0, nsec};
            idx_q    <= 9'd0;
            phase_q  <= PH_ADDR;
          end
        end
        RD_REQ: begin
          if (sd_ack) begin
            sd_rd_q <= 1'b0;
            state_q <= RD_XFER;
          end
        end
        RD_XFER: begin
          if (!sd_ack) begin
            state_q <= RD_COPY;
            idx_q   <= 9'd0;
            phase_q <= PH_ADDR;
          end
        end
        RD_COPY, WR_FILL: begin
          // Address/data settle one cycle before the request toggles and hold until the ack matches.
          case (phase_q)
            PH_ADDR: begin
              mem_addr_q <= {sector_q[10:0], idx_q};
              mem_din_q  <= buf_q[idx_q];
              mem_we_q   <= (state_q == RD_COPY);
              phase_q    <= PH_REQ;
            end
            PH_REQ: begin
              mem_req_q <= ~mem_req_q;
              phase_q   <= PH_WAIT;
            end
            default: begin
              if (mem_done) begin
                phase_q <= PH_ADDR;
                idx_q   <= idx_q + 9'd1;
                if (idx_q == 9'd511) begin
                  mem_we_q <= 1'b0;
                  if (state_q == RD_COPY) begin
                    sector_q <= sector_inc;
                    if (last_sector) begin
                      state_q <= IDLE;
                    end else begin
                      sd_lba_q <= {16'd0, sector_inc};
                      sd_rd_q  <= 1'b1;
                      state_q  <= RD_REQ;
                    end
                  end else begin
                    sd_lba_q <= {16'd0, sector_q};
                    sd_wr_q  <= 1'b1;
                    state_q  <= WR_REQ;
                  end
                end
              end
            end
          endcase
        end
        WR_REQ: begin
          if (sd_ack) begin
            sd_wr_q <= 1'b0;
            state_q <= WR_XFER;
          end
        end
        WR_XFER: begin
          if (!sd_ack) begin
            sector_q <= sector_inc;
            idx_q    <= 9'd0;
            phase_q  <= PH_ADDR;
            state_q  <= last_sector ? IDLE : WR_FILL;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign sd_lba      = sd_lba_q;
  assign sd_rd       = sd_rd_q;
  assign sd_wr       = sd_wr_q;
  assign sd_buff_din = sd_buff_din_q;
  assign mem_addr    = mem_addr_q;
  assign mem_din     = mem_din_q;
  assign mem_we      = mem_we_q;
  assign mem_req     = mem_req_q;
  assign busy        = (state_q != IDLE);
  assign mounted     = mounted_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_sram_backup.sv
// Bench for sram_backup: SD host and toggle-handshake memory models with expected-value queues.
// Handshakes: sd_rd/sd_wr hold until sd_ack is seen; memory completes when mem_ack equals mem_req.
module tb_sram_backup;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        img_mounted;
  logic [31:0] img_size;
  logic [23:0] ram_mask;
  logic        save_req;
  logic        cpu_wr;
  logic [31:0] sd_lba;
  logic        sd_rd;
  logic        sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic [7:0]  sd_buff_din;
  logic        sd_buff_wr;
  logic [19:0] mem_addr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic        mem_we;
  logic        mem_req;
  logic        mem_ack;
  logic        busy;
  logic        mounted;
  logic [2:0]  dbg_state;

  sram_backup dut (
    .clk_sys(clk_sys), .reset(reset), .img_mounted(img_mounted), .img_size(img_size),
    .ram_mask(ram_mask), .save_req(save_req), .cpu_wr(cpu_wr), .sd_lba(sd_lba),
    .sd_rd(sd_rd), .sd_wr(sd_wr), .sd_ack(sd_ack), .sd_buff_addr(sd_buff_addr),
    .sd_buff_dout(sd_buff_dout), .sd_buff_din(sd_buff_din), .sd_buff_wr(sd_buff_wr),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout), .mem_we(mem_we),
    .mem_req(mem_req), .mem_ack(mem_ack), .busy(busy), .mounted(mounted),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk_sys = ~clk_sys;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  int tests_run    = 0;
  int tests_failed = 0;
  int n_mem_wr = 0, n_mem_rd = 0, n_sd_rd = 0, n_sd_wr = 0;
  bit timed_out = 1'b0;

  logic [27:0] exp_mem_q[$];    // {addr, data} of each expected memory write
  logic [31:0] exp_rd_lba_q[$];
  logic [31:0] exp_wr_lba_q[$];
  logic [7:0]  exp_sd_q[$];     // bytes the SD host must read back during saves
  logic [7:0]  mem_model [0:1048575];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: unexpected or missing event", name);
  endtask

  function automatic logic [7:0] img_byte(input int unsigned off);
    int unsigned v;
    v = off * 13 + (off >> 9) + 5;
    return v[7:0];
  endfunction

  // ---------------- memory responder + write monitor ----------------
  logic [19:0] r_addr;
  logic [7:0]  r_din;
  logic        r_we;
  logic        r_stable;
  int          r_dly;

  initial begin
    mem_ack  = 1'b1;
    mem_dout = 8'd0;
    forever begin
      @(negedge clk_sys);
      if (!reset && (mem_req !== mem_ack)) begin
        r_addr = mem_addr; r_din = mem_din; r_we = mem_we; r_stable = 1'b1;
        r_dly = $urandom_range(0, 7);
        if (r_we) begin
          n_mem_wr++;
          if (exp_mem_q.size() == 0) fail_now("mem_wr_extra");
          else check("mem_wr", {4'd0, r_addr, r_din}, {4'd0, exp_mem_q.pop_front()});
          mem_model[r_addr] = r_din;
        end else begin
          n_mem_rd++;
        end
        for (int k = 0; k < r_dly; k++) begin
          @(negedge clk_sys);
          if (reset) break;
          if (mem_addr !== r_addr || mem_din !== r_din || mem_we !== r_we) r_stable = 1'b0;
        end
        if (!reset) begin
          if (!r_we) mem_dout = mem_model[r_addr];
          mem_ack = ~mem_ack;
          check("mem_stable", {31'd0, r_stable}, 32'd1);
        end
      end
    end
  end

  // ---------------- SD host model + readback monitor ----------------
  logic [31:0] h_lba;
  bit          h_skip;

  initial begin
    sd_ack = 1'b0; sd_buff_addr = 9'd0; sd_buff_dout = 8'd0; sd_buff_wr = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (!reset && sd_rd && !sd_ack) begin
        n_sd_rd++;
        h_lba = sd_lba;
        if (exp_rd_lba_q.size() == 0) fail_now("sd_rd_extra");
        else check("sd_rd_lba", h_lba, exp_rd_lba_q.pop_front());
        sd_ack = 1'b1;
        for (int i = 0; i < 512; i++) begin
          if (reset) break;
          sd_buff_addr = 9'(i);
          sd_buff_dout = img_byte(h_lba * 512 + i);
          sd_buff_wr   = 1'b1;
          @(negedge clk_sys);
        end
        sd_buff_wr = 1'b0;
        sd_ack     = 1'b0;
      end else if (!reset && sd_wr && !sd_ack) begin
        n_sd_wr++;
        h_skip = (exp_wr_lba_q.size() == 0);
        if (h_skip) fail_now("sd_wr_extra");
        else check("sd_wr_lba", sd_lba, exp_wr_lba_q.pop_front());
        sd_ack       = 1'b1;
        sd_buff_addr = 9'd0;
        for (int i = 0; i < 512; i++) begin
          @(negedge clk_sys);
          if (reset) break;
          if (!h_skip) begin
            if (exp_sd_q.size() == 0) begin
              fail_now("sd_byte_extra");
              h_skip = 1'b1;
            end else begin
              check("sd_buff_din", {24'd0, sd_buff_din}, {24'd0, exp_sd_q.pop_front()});
            end
          end
          sd_buff_addr = 9'(i + 1);
        end
        sd_ack = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_mount(input logic [31:0] size, input logic [23:0] mask);
    @(negedge clk_sys);
    img_size = size; ram_mask = mask; img_mounted = 1'b1;
    @(negedge clk_sys);
    img_mounted = 1'b0;
  endtask

  task automatic pulse_save();
    @(negedge clk_sys);
    save_req = 1'b1;
    @(negedge clk_sys);
    save_req = 1'b0;
  endtask

  task automatic pulse_cpu_wr();
    @(negedge clk_sys);
    cpu_wr = 1'b1;
    @(negedge clk_sys);
    cpu_wr = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    tests_run++;
    if (busy) begin
      tests_failed++;
      timed_out = 1'b1;
      $display("FAIL %s: busy still 1 after %0d cycles, expected 0", name, budget);
    end
  endtask

  task automatic quiet_check(input string name, input int cycles);
    bit saw;
    saw = 1'b0;
    repeat (cycles) begin
      @(negedge clk_sys);
      if (busy) saw = 1'b1;
    end
    check(name, {31'd0, saw}, 32'd0);
  endtask

  task automatic push_save(input int sectors);
    for (int s = 0; s < sectors; s++) begin
      exp_wr_lba_q.push_back(32'(s));
      for (int i = 0; i < 512; i++) exp_sd_q.push_back(mem_model[s * 512 + i]);
    end
  endtask

  task automatic run_tests();
    int base_wr, base_rd, base_sdw, base_sdr, bad, n;

    // reset values, mem_ack held at 1 so mem_req must follow it
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_mounted", {31'd0, mounted}, 32'd0);
    check("rst_sd_rd", {31'd0, sd_rd}, 32'd0);
    check("rst_sd_wr", {31'd0, sd_wr}, 32'd0);
    check("rst_mem_we", {31'd0, mem_we}, 32'd0);
    check("rst_sd_lba", sd_lba, 32'd0);
    check("rst_mem_addr", {12'd0, mem_addr}, 32'd0);
    check("rst_mem_din", {24'd0, mem_din}, 32'd0);
    check("rst_mem_req", {31'd0, mem_req}, 32'd1);
    @(negedge clk_sys);
    reset = 1'b0;

    // zero-size image: not mounted, nothing loaded
    pulse_mount(32'd0, 24'h7FF);
    quiet_check("zero_size_quiet", 10);
    check("zero_size_mounted", {31'd0, mounted}, 32'd0);

    // 2 KB save RAM, 4 KB image: four sectors loaded
    base_wr = n_mem_wr;
    for (int s = 0; s < 4; s++) exp_rd_lba_q.push_back(32'(s));
    for (int i = 0; i < 2048; i++) exp_mem_q.push_back({20'(i), img_byte(i)});
    pulse_mount(32'd4096, 24'h7FF);
    check("load4_busy", {31'd0, busy}, 32'd1);
    wait_done("load4_done", 30000);
    if (timed_out) return;
    check("load4_mounted", {31'd0, mounted}, 32'd1);
    check("load4_mem_q_left", 32'(exp_mem_q.size()), 32'd0);
    check("load4_lba_q_left", 32'(exp_rd_lba_q.size()), 32'd0);
    check("load4_wr_count", 32'(n_mem_wr - base_wr), 32'd2048);

    // image smaller than the RAM: load count limited to 2 sectors
    for (int i = 'h400; i < 'h2000; i++) mem_model[i] = 8'hA5;
    base_sdr = n_sd_rd;
    for (int s = 0; s < 2; s++) exp_rd_lba_q.push_back(32'(s));
    for (int i = 0; i < 1024; i++) exp_mem_q.push_back({20'(i), img_byte(i)});
    pulse_mount(32'd1024, 24'h1FFF);
    wait_done("load2_done", 15000);
    if (timed_out) return;
    check("load2_mem_q_left", 32'(exp_mem_q.size()), 32'd0);
    check("load2_sd_rd_count", 32'(n_sd_rd - base_sdr), 32'd2);
    bad = 0;
    for (int i = 'h400; i < 'h2000; i++) if (mem_model[i] !== 8'hA5) bad++;
    check("load2_untouched", 32'(bad), 32'd0);

    // no save RAM: mounted but nothing loaded, and a save does nothing
    base_sdw = n_sd_wr;
    pulse_mount(32'd4096, 24'h0);
    quiet_check("nomask_load_quiet", 10);
    check("nomask_mounted", {31'd0, mounted}, 32'd1);
    pulse_cpu_wr();
    pulse_save();
    quiet_check("nomask_save_quiet", 10);
    check("nomask_sd_wr_count", 32'(n_sd_wr - base_sdw), 32'd0);

    // 1 KB save: 1024 reads, two sectors written back
    ram_mask = 24'h3FF;
    for (int i = 0; i < 1024; i++) mem_model[i] = 8'(i * 3 + 17);
    push_save(2);
    base_rd = n_mem_rd; base_sdw = n_sd_wr;
    pulse_cpu_wr();
    pulse_save();
    check("save_busy", {31'd0, busy}, 32'd1);
    wait_done("save_done", 15000);
    if (timed_out) return;
    check("save_rd_count", 32'(n_mem_rd - base_rd), 32'd1024);
    check("save_sd_wr_count", 32'(n_sd_wr - base_sdw), 32'd2);
    check("save_sd_q_left", 32'(exp_sd_q.size()), 32'd0);

    // mount beats save in the same cycle; zero size also unmounts
    pulse_cpu_wr();
    base_sdw = n_sd_wr;
    @(negedge clk_sys);
    img_size = 32'd0; img_mounted = 1'b1; save_req = 1'b1;
    @(negedge clk_sys);
    img_mounted = 1'b0; save_req = 1'b0;
    quiet_check("prio_quiet", 10);
    check("prio_mounted", {31'd0, mounted}, 32'd0);
    check("prio_sd_wr_count", 32'(n_sd_wr - base_sdw), 32'd0);

    // reset in the middle of a sector read
    exp_rd_lba_q.push_back(32'd0);
    pulse_mount(32'd4096, 24'h7FF);
    n = 0;
    while (dbg_state != 3'd2 && n < 100) begin
      @(negedge clk_sys);
      n++;
    end
    check("rst_mid_reached_xfer", {29'd0, dbg_state}, 32'd2);
    reset = 1'b1;
    #1;
    check("rst_mid_sd_rd", {31'd0, sd_rd}, 32'd0);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    repeat (3) @(negedge clk_sys);
    exp_mem_q.delete();
    exp_rd_lba_q.delete();
    reset = 1'b0;
    check("rst_mid_mounted", {31'd0, mounted}, 32'd0);
    base_wr = n_mem_wr; base_rd = n_mem_rd; base_sdw = n_sd_wr;
    pulse_cpu_wr();
    pulse_save();
    quiet_check("rst_mid_save_quiet", 30);
    check("rst_mid_sd_wr_count", 32'(n_sd_wr - base_sdw), 32'd0);
    check("rst_mid_mem_count", 32'(n_mem_wr - base_wr + n_mem_rd - base_rd), 32'd0);

`ifdef SRAM_BACKUP_DIRTY_EN
    // dirty tracking: a clean RAM is not saved; a write enables exactly one save
    pulse_mount(32'd4096, 24'h0);
    ram_mask = 24'h3FF;
    base_sdw = n_sd_wr;
    pulse_save();
    quiet_check("dirty_clean_quiet", 10);
    check("dirty_clean_sd_wr", 32'(n_sd_wr - base_sdw), 32'd0);
    for (int i = 0; i < 1024; i++) mem_model[i] = 8'(i ^ 8'h5A);
    push_save(2);
    pulse_cpu_wr();
    pulse_save();
    check("dirty_save_busy", {31'd0, busy}, 32'd1);
    wait_done("dirty_save_done", 15000);
    if (timed_out) return;
    check("dirty_save_sd_wr", 32'(n_sd_wr - base_sdw), 32'd2);
    check("dirty_save_q_left", 32'(exp_sd_q.size()), 32'd0);
    pulse_save();
    quiet_check("dirty_cleared_quiet", 10);
    check("dirty_cleared_sd_wr", 32'(n_sd_wr - base_sdw), 32'd2);
`endif
  endtask

  initial begin
    reset = 1'b1; img_mounted = 1'b0; img_size = 32'd0; ram_mask = 24'd0;
    save_req = 1'b0; cpu_wr = 1'b0;
    repeat (3) @(negedge clk_sys);
    run_tests();
    repeat (5) @(negedge clk_sys);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sram_backup.md
SRAM_BACKUP -- requirements
Module: sram_backup

Interface
REQ-001 SHALL have port: clk_sys  in  1  system clock; all logic on its rising edge.
REQ-002 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: img_mounted in 1 (one-cycle pulse, image attached); img_size in 32 (image bytes); ram_mask in 24 (save-RAM size minus 1; 0 = no save RAM).
REQ-004 SHALL have ports: save_req in 1 (one-cycle pulse, write RAM to image); cpu_wr in 1 (one-cycle pulse per CPU save-RAM write).
REQ-005 SHALL have ports: sd_lba out 32; sd_rd out 1; sd_wr out 1; sd_ack in 1; sd_buff_addr in 9; sd_buff_dout in 8; sd_buff_din out 8; sd_buff_wr in 1.
REQ-006 SHALL have ports: mem_addr out 20; mem_din out 8; mem_dout in 8; mem_we out 1; mem_req out 1 (toggle); mem_ack in 1 (toggle).
REQ-007 SHALL have ports: busy out 1 (high in any non-IDLE state; holds the core in reset); mounted out 1 (image attached and size nonzero).

Function
REQ-008 SHALL contain a 512x8 sector buffer; the SD side writes it at sd_buff_addr when sd_buff_wr=1, and reads it onto sd_buff_din with one-cycle latency.
REQ-009 SHALL compute nsec = ram_mask[23:9]+1 when ram_mask is nonzero, else 0; load count = min(nsec, img_size[31:9]).
REQ-010 SHALL use states IDLE, RD_REQ, RD_XFER, RD_COPY, WR_FILL, WR_REQ, WR_XFER.
REQ-011 IDLE: img_mounted with nonzero load count -> RD_REQ with sector=0; save_req with mounted=1 and nsec nonzero -> WR_FILL with sector=0; otherwise stay.
REQ-012 img_mounted SHALL set mounted to (img_size != 0) in every state; in IDLE, img_mounted takes priority over save_req in the same cycle.
REQ-013 RD_REQ/WR_REQ SHALL drive sd_lba=sector and hold sd_rd (resp. sd_wr)=1 until the cycle sd_ack is sampled 1, then drop it and enter RD_XFER (resp. WR_XFER).
REQ-014 RD_XFER/WR_XFER SHALL wait for sd_ack=0; RD_XFER then enters RD_COPY, WR_XFER increments sector and enters WR_FILL, or IDLE when sector reached nsec.
REQ-015 RD_COPY SHALL write buffer bytes 0..511 to mem_addr={sector[10:0],idx} with mem_we=1, one memory transaction each, then increment sector and go to RD_REQ, or IDLE when sector reached the load count.
REQ-016 WR_FILL SHALL read mem_addr={sector[10:0],idx} for idx 0..511 with mem_we=0, store mem_dout into the buffer, then go to WR_REQ.
REQ-017 Memory handshake: toggle mem_req with mem_addr/mem_din/mem_we already stable; at most one outstanding; complete when mem_ack==mem_req; read data SHALL be captured in the completion cycle.
REQ-018 mem_addr, mem_din and mem_we SHALL stay constant while a transaction is outstanding.
REQ-019 mem_addr SHALL wrap within 20 bits; sectors beyond the 1 MB window are not addressed.
REQ-020 save_req and cpu_wr SHALL be ignored when not in IDLE, except as stated in REQ-029.
REQ-021 An img_mounted pulse outside IDLE SHALL only update mounted; the current operation completes.

Reset
REQ-022 Reset SHALL force IDLE asynchronously.
REQ-023 Reset SHALL clear sd_rd, sd_wr, mem_we, busy and mounted, and set sd_lba=0, mem_addr=0, mem_din=0.
REQ-024 Reset SHALL set mem_req equal to the sampled mem_ack.
REQ-025 Buffer contents SHALL be undefined after reset.
REQ-026 Reset mid-transfer SHALL abandon the operation with no resumption; sd_ack edges after reset SHALL be ignored in IDLE.

Configuration
REQ-027 Macro SRAM_BACKUP_DIRTY_EN SHALL select dirty tracking.
REQ-028 With SRAM_BACKUP_DIRTY_EN defined, a dirty flag SHALL be set by cpu_wr and cleared by reset, img_mounted and entry to WR_FILL.
REQ-029 With SRAM_BACKUP_DIRTY_EN defined, save_req SHALL start a save only when the dirty flag is set; cpu_wr during a save re-sets the flag.
REQ-030 Without SRAM_BACKUP_DIRTY_EN, every qualifying save_req SHALL save, and cpu_wr SHALL be unused.

Verification
REQ-031 ram_mask=0x7FF, img_size=4096, img_mounted -> 4 sd_rd sectors at LBA 0..3, 2048 mem writes to 0x00000..0x007FF matching image bytes, then busy=0.
REQ-032 ram_mask=0x1FFF, img_size=1024 -> exactly 2 sectors loaded (LBA 0,1); mem 0x400..0x1FFF untouched.
REQ-033 mounted=1, ram_mask=0x3FF, save_req -> 1024 mem reads, sd_wr at LBA 0 then 1, sd_buff_din at addr N equals mem byte N of that sector.
REQ-034 mem_ack delayed 0..7 random cycles per transaction -> no lost or duplicated byte; mem_addr stable while outstanding.
REQ-035 Reset asserted during RD_XFER -> sd_rd=0 and busy=0 immediately; a following save_req with mounted=0 -> no activity.
REQ-036 SRAM_BACKUP_DIRTY_EN defined: save_req without a prior cpu_wr -> no sd_wr; cpu_wr then save_req -> save runs and dirty clears.
